exception_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 35 +++
 rtl/exc_prio.sv | 66 ++++++
 rtl/exception_unit.sv | 148 ++++++++++++++
 tb/tb_exception_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared exception codes, exception FSM states and the
//                default exception vector used by the writeback exception
//                controller and its priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // MIPS ExcCode values reported through CAUSE
    typedef enum logic [4:0] {
        INT  = 5'd0,
        ADEL = 5'd4,
        ADES = 5'd5,
        SYS  = 5'd8,
        BP   = 5'd9,
        RI   = 5'd10,
        OV   = 5'd12
    } exc_code_t;

    // Exception sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        REDIR = 2'd2
    } exc_state_t;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

    // Width of the drain counter; holds FLUSH_CYCLES-1 for FLUSH_CYCLES up to 15
    localparam int CNT_W = 4;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/exc_prio.sv
`default_nettype none
// ============================================================================
//  Module      : exc_prio
//  Description : Combinational exception priority encoder. Picks the single
//                highest-priority cause among the writeback fault flags, the
//                counter interrupt and an ERET issued outside kernel mode,
//                and selects the matching bad virtual address.
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_prio
    import cpu_pkg::*;
(
    input  logic        int_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        ovf_i,
    input  logic        adel_d_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic        kernel_mode_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] bad_va_i,
    output logic        any_exc_o,
    output logic        is_return_o,
    output logic [4:0]  cause_o,
    output logic [31:0] bad_va_o
);

    // ERET from user mode is a privileged-instruction fault, reported as RI
    logic ri_eff;
    assign ri_eff = ri_i | (eret_i & ~kernel_mode_i);

    assign any_exc_o   = int_i | adel_if_i | ri_eff | syscall_i | break_i |
                         ovf_i | adel_d_i | ades_i;
    assign is_return_o = eret_i & kernel_mode_i & ~any_exc_o;

    // Fixed-priority selection of cause and bad address (interrupt first)
    always_comb begin
        cause_o  = INT;
        bad_va_o = 32'h0000_0000;
        if (int_i) begin
            cause_o = INT;
        end else if (adel_if_i) begin
            cause_o  = ADEL;
            bad_va_o = pc_i;
        end else if (ri_eff) begin
            cause_o = RI;
        end else if (syscall_i) begin
            cause_o = SYS;
        end else if (break_i) begin
            cause_o = BP;
        end else if (ovf_i) begin
            cause_o = OV;
        end else if (adel_d_i) begin
            cause_o  = ADEL;
            bad_va_o = bad_va_i;
        end else if (ades_i) begin
            cause_o  = ADES;
            bad_va_o = bad_va_i;
        end
    end

endmodule : exc_prio
`default_nettype wire

// File: rtl/exception_unit.sv
`default_nettype none
// ============================================================================
//  Module      : exception_unit
//  Description : Writeback-stage exception controller. Converts fault flags,
//                ERET and the counter interrupt into one registered entry or
//                return event, squashes younger stages for FLUSH_CYCLES and
//                then redirects fetch to the vector or the saved EPC.
//  Revision    : 1.0 - initial release
// ============================================================================
module exception_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid_i,
    input  logic [31:0] wb_pc_i,
    input  logic        wb_is_branch_i,
    input  logic        wb_adel_i_i,
    input  logic        wb_ri_i,
    input  logic        wb_syscall_i,
    input  logic        wb_break_i,
    input  logic        wb_ovf_i,
    input  logic        wb_adel_d_i,
    input  logic        wb_ades_i,
    input  logic [31:0] wb_bad_va_i,
    input  logic        wb_eret_i,
    input  logic        kernel_mode_i,
    input  logic        int_counter_i,
    input  logic [31:0] epc_q_i,
    output logic        e_enter_o,
    output logic        eret_o,
    output logic [4:0]  cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] bad_va_o,
    output logic        delay_slot_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    exc_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bd_q;
    logic             e_enter_q, eret_q, redirect_q, delay_slot_q;
    logic [4:0]       cause_q;
    logic [31:0]      epc_q, bad_va_q, redirect_pc_q;

    logic             any_exc, is_return, event_d;
    logic [4:0]       cause_d;
    logic [31:0]      bad_va_d, epc_d;

    exc_prio u_prio (
        .int_i         (int_counter_i),
        .adel_if_i     (wb_adel_i_i),
        .ri_i          (wb_ri_i),
        .syscall_i     (wb_syscall_i),
        .break_i       (wb_break_i),
        .ovf_i         (wb_ovf_i),
        .adel_d_i      (wb_adel_d_i),
        .ades_i        (wb_ades_i),
        .eret_i        (wb_eret_i),
        .kernel_mode_i (kernel_mode_i),
        .pc_i          (wb_pc_i),
        .bad_va_i      (wb_bad_va_i),
        .any_exc_o     (any_exc),
        .is_return_o   (is_return),
        .cause_o       (cause_d),
        .bad_va_o      (bad_va_d)
    );

    // WB inputs only matter while idle; bubbles never raise an event
    assign event_d = (state_q == IDLE) & wb_valid_i & (any_exc | is_return);

    // A victim sitting in a delay slot restarts at its branch
    assign epc_d = bd_q ? (wb_pc_i - 32'd4) : wb_pc_i;

    // Mealy flush covers the victim in the detection cycle; forced low in reset
    assign flush_o = rst_n & (event_d | (state_q == DRAIN));

    // Exception sequencer, delay-slot tracking and registered event outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bd_q          <= 1'b0;
            e_enter_q     <= 1'b0;
            eret_q        <= 1'b0;
            redirect_q    <= 1'b0;
            delay_slot_q  <= 1'b0;
            cause_q       <= 5'd0;
            epc_q         <= 32'h0;
            bad_va_q      <= 32'h0;
            redirect_pc_q <= 32'h0;
        end else begin
            e_enter_q  <= 1'b0;
            eret_q     <= 1'b0;
            redirect_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (event_d) begin
                        state_q       <= DRAIN;
                        cnt_q         <= CNT_LOAD;
                        bd_q          <= 1'b0;
                        e_enter_q     <= any_exc;
                        eret_q        <= ~any_exc;
                        cause_q       <= cause_d;
                        epc_q         <= epc_d;
                        bad_va_q      <= bad_va_d;
                        delay_slot_q  <= bd_q;
                        redirect_pc_q <= any_exc ? EXC_VECTOR : epc_q_i;
                    end else if (wb_valid_i) begin
                        bd_q <= wb_is_branch_i;
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q    <= REDIR;
                        redirect_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                REDIR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign e_enter_o     = e_enter_q;
    assign eret_o        = eret_q;
    assign cause_o       = cause_q;
    assign epc_o         = epc_q;
    assign bad_va_o      = bad_va_q;
    assign delay_slot_o  = delay_slot_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;

endmodule : exception_unit
`default_nettype wire

// File: tb/tb_exception_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exception_unit
//  Description : Directed self-checking bench for exception_unit with a
//                scoreboard of expected entry/return events and redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exception_unit;

    typedef struct {
        logic        entry;
        logic [4:0]  cause;
        logic [31:0] epc;
        logic [31:0] bad_va;
        logic        ds;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_is_branch, wb_adel_i, wb_ri, wb_syscall, wb_break;
    logic        wb_ovf, wb_adel_d, wb_ades, wb_eret, kernel_mode, int_counter;
    logic [31:0] wb_pc, wb_bad_va, epc_q;
    logic        e_enter, eret, delay_slot, flush, redirect;
    logic [4:0]  cause;
    logic [31:0] epc, bad_va, redirect_pc;

    int          errors = 0;
    int          checks = 0;
    exp_t        evq[$];
    logic [31:0] rdq[$];

    always #5 clk = ~clk;

    exception_unit #(.EXC_VECTOR(32'h0000_0180), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid_i(wb_valid), .wb_pc_i(wb_pc), .wb_is_branch_i(wb_is_branch),
        .wb_adel_i_i(wb_adel_i), .wb_ri_i(wb_ri), .wb_syscall_i(wb_syscall),
        .wb_break_i(wb_break), .wb_ovf_i(wb_ovf), .wb_adel_d_i(wb_adel_d),
        .wb_ades_i(wb_ades), .wb_bad_va_i(wb_bad_va), .wb_eret_i(wb_eret),
        .kernel_mode_i(kernel_mode), .int_counter_i(int_counter), .epc_q_i(epc_q),
        .e_enter_o(e_enter), .eret_o(eret), .cause_o(cause), .epc_o(epc),
        .bad_va_o(bad_va), .delay_slot_o(delay_slot), .flush_o(flush),
        .redirect_o(redirect), .redirect_pc_o(redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wb_valid = 0; wb_is_branch = 0; wb_adel_i = 0; wb_ri = 0; wb_syscall = 0;
        wb_break = 0; wb_ovf = 0; wb_adel_d = 0; wb_ades = 0; wb_eret = 0;
        kernel_mode = 0; int_counter = 0;
        wb_pc = 32'h0; wb_bad_va = 32'h0; epc_q = 32'hDEAD_BEEF;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push(input logic entry, input logic [4:0] c, input logic [31:0] pc,
                        input logic [31:0] va, input logic ds, input logic [31:0] rpc);
        exp_t e;
        e.entry = entry; e.cause = c; e.epc = pc; e.bad_va = va; e.ds = ds;
        evq.push_back(e);
        rdq.push_back(rpc);
    endtask

    // Walks T+1..T+3 after a detection cycle, checking flush and strobe timing
    task automatic drain(input string tag, input logic clear);
        cyc(); if (clear) clr(); smp();
        chk({tag, "_flush_t1"}, 32'(flush), 32'd1);
        chk({tag, "_strobe_t1"}, 32'(e_enter | eret), 32'd1);
        cyc(); smp();
        chk({tag, "_flush_t2"}, 32'(flush), 32'd1);
        chk({tag, "_redir_t2"}, 32'(redirect), 32'd0);
        cyc(); smp();
        chk({tag, "_flush_t3"}, 32'(flush), 32'd0);
        chk({tag, "_redir_t3"}, 32'(redirect), 32'd1);
    endtask

    // Scoreboard: every strobe/redirect must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (e_enter | eret) begin
                if (evq.size() == 0) begin
                    chk("sb_unexpected_event", {30'd0, e_enter, eret}, 32'd0);
                end else begin
                    exp_t e;
                    e = evq.pop_front();
                    chk("sb_e_enter", 32'(e_enter), 32'(e.entry));
                    chk("sb_eret", 32'(eret), 32'(!e.entry));
                    if (e.entry) begin
                        chk("sb_cause", 32'(cause), 32'(e.cause));
                        chk("sb_epc", epc, e.epc);
                        chk("sb_bad_va", bad_va, e.bad_va);
                        chk("sb_delay_slot", 32'(delay_slot), 32'(e.ds));
                    end
                end
            end
            if (redirect) begin
                if (rdq.size() == 0) chk("sb_unexpected_redirect", 32'(redirect), 32'd0);
                else chk("sb_redirect_pc", redirect_pc, rdq.pop_front());
            end
        end
    end

    initial begin
        clr();
        rst_n = 0;
        // Reset state
        repeat (2) cyc();
        smp();
        chk("rst_e_enter", 32'(e_enter), 0); chk("rst_eret", 32'(eret), 0);
        chk("rst_cause", 32'(cause), 0);     chk("rst_epc", epc, 0);
        chk("rst_bad_va", bad_va, 0);        chk("rst_ds", 32'(delay_slot), 0);
        chk("rst_flush", 32'(flush), 0);     chk("rst_redirect", 32'(redirect), 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        cyc(); rst_n = 1;
        repeat (2) cyc();

        // Syscall
        wb_valid = 1; wb_pc = 32'h400; wb_syscall = 1;
        push(1, 5'd8, 32'h400, 32'h0, 0, 32'h180);
        smp(); chk("sys_flush_t0", 32'(flush), 1); chk("sys_e_enter_t0", 32'(e_enter), 0);
        drain("sys", 1);

        // Branch commit, then OVF+ADES in its delay slot
        cyc(); wb_valid = 1; wb_pc = 32'h100; wb_is_branch = 1;
        smp(); chk("br_flush", 32'(flush), 0);
        cyc(); clr(); wb_valid = 1; wb_pc = 32'h104; wb_ovf = 1; wb_ades = 1; wb_bad_va = 32'h44;
        push(1, 5'd12, 32'h100, 32'h0, 1, 32'h180);
        smp(); chk("ds_flush_t0", 32'(flush), 1);
        drain("ds", 1);

        // Store address error
        cyc(); wb_valid = 1; wb_pc = 32'h500; wb_ades = 1; wb_bad_va = 32'h1003;
        push(1, 5'd5, 32'h500, 32'h1003, 0, 32'h180);
        drain("ades", 1);

        // Legal ERET: EPC_Q sampled in detection cycle
        cyc(); wb_valid = 1; wb_pc = 32'h600; wb_eret = 1; kernel_mode = 1; epc_q = 32'h888;
        push(0, 5'd0, 32'h0, 32'h0, 0, 32'h888);
        smp(); chk("eret_flush_t0", 32'(flush), 1);
        cyc(); clr(); smp(); chk("eret_no_e_enter", 32'(e_enter), 0);
        cyc(); smp(); cyc(); smp(); chk("eret_redir", 32'(redirect), 1);

        // ERET from user mode is RI
        cyc(); wb_valid = 1; wb_pc = 32'h640; wb_eret = 1; kernel_mode = 0;
        push(1, 5'd10, 32'h640, 32'h0, 0, 32'h180);
        drain("ueret", 1);

        // Interrupt against bubbles, then with BREAK
        cyc(); int_counter = 1;
        smp(); chk("int_bubble_flush0", 32'(flush), 0);
        cyc(); smp(); chk("int_bubble_flush1", 32'(flush), 0);
        cyc(); wb_valid = 1; wb_pc = 32'h200; wb_break = 1;
        push(1, 5'd0, 32'h200, 32'h0, 0, 32'h180);
        smp(); chk("int_victim_flush", 32'(flush), 1);
        drain("int", 1);

        // ADEL_I outranks ADEL_D; bad address is the PC
        cyc(); wb_valid = 1; wb_pc = 32'h301; wb_adel_i = 1; wb_adel_d = 1; wb_bad_va = 32'h5555;
        push(1, 5'd4, 32'h301, 32'h301, 0, 32'h180);
        drain("adeli", 1);

        // ADEL_D alone reports the data address
        cyc(); wb_valid = 1; wb_pc = 32'h320; wb_adel_d = 1; wb_bad_va = 32'h777;
        push(1, 5'd4, 32'h320, 32'h777, 0, 32'h180);
        drain("adeld", 1);

        // Delay-slot flag cleared by the next plain commit
        cyc(); wb_valid = 1; wb_pc = 32'h1000; wb_is_branch = 1;
        cyc(); wb_is_branch = 0; wb_pc = 32'h1004;
        cyc(); wb_pc = 32'h1008; wb_ovf = 1;
        push(1, 5'd12, 32'h1008, 32'h0, 0, 32'h180);
        drain("bdclr", 1);

        // Delay-slot EPC wraps below zero; RI outranks SYSCALL/BREAK
        cyc(); wb_valid = 1; wb_pc = 32'hFFFF_FFFC; wb_is_branch = 1;
        cyc(); clr(); wb_valid = 1; wb_pc = 32'h0; wb_ri = 1; wb_syscall = 1; wb_break = 1;
        push(1, 5'd10, 32'hFFFF_FFFC, 32'h0, 1, 32'h180);
        drain("wrap", 1);

        // Mid-sequence reset aborts everything
        cyc(); wb_valid = 1; wb_pc = 32'h700; wb_syscall = 1;
        smp(); chk("rstmid_flush_t0", 32'(flush), 1);
        cyc(); clr(); rst_n = 0; #1;
        chk("rstmid_e_enter", 32'(e_enter), 0); chk("rstmid_flush", 32'(flush), 0);
        chk("rstmid_cause", 32'(cause), 0);     chk("rstmid_epc", epc, 0);
        chk("rstmid_redir_pc", redirect_pc, 0);
        cyc(); cyc(); rst_n = 1;
        repeat (4) begin cyc(); smp(); chk("rstmid_no_redirect", 32'(redirect), 0); end

        // Back-to-back: second event held through DRAIN/REDIR
        cyc(); wb_valid = 1; wb_pc = 32'h800; wb_break = 1;
        push(1, 5'd9, 32'h800, 32'h0, 0, 32'h180);
        smp(); chk("b2b_flush_t0", 32'(flush), 1);
        cyc(); clr(); wb_valid = 1; wb_pc = 32'h900; wb_syscall = 1;
        smp(); chk("b2b_flush_t1", 32'(flush), 1);
        cyc(); smp(); cyc(); smp();
        chk("b2b_flush_t3", 32'(flush), 0); chk("b2b_redir_t3", 32'(redirect), 1);
        cyc();
        push(1, 5'd8, 32'h900, 32'h0, 0, 32'h180);
        smp(); chk("b2b_flush_t4", 32'(flush), 1);
        drain("b2b2", 1);

        repeat (3) cyc();
        chk("sb_events_drained", 32'(evq.size()), 0);
        chk("sb_redirects_drained", 32'(rdq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_exception_unit
`default_nettype wire
